// File: rtl/arbiter_puf_pkg.sv
// Shared types and LFSR tap tables for the arbiter PUF measurement engine.
package arbiter_puf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LAUNCH,
    ST_DONE
  } puf_state_e;

  localparam int TAP_W = 128;

  // Tap exponents of a maximal-length Fibonacci polynomial per supported width.
  localparam int TAPS_32  [4] = '{32, 22, 2, 1};
  localparam int TAPS_64  [4] = '{64, 63, 61, 60};
  localparam int TAPS_128 [4] = '{128, 126, 101, 99};

  function automatic logic [TAP_W-1:0] tap_mask(input int n_stages);
    logic [TAP_W-1:0] m;
    int t [4];
    m = '0;
    case (n_stages)
      32:      t = TAPS_32;
      128:     t = TAPS_128;
      default: t = TAPS_64;
    endcase
    for (int i = 0; i < 4; i++) begin
      m[7'(t[i] - 1)] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/puf_chal_lfsr.sv
// Challenge generator: Fibonacci LFSR with seed load and all-zero seed substitution.
module puf_chal_lfsr
  import arbiter_puf_pkg::*;
#(
  parameter int N_STAGES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [N_STAGES-1:0] seed,
  output logic [N_STAGES-1:0] state
);

  localparam logic [TAP_W-1:0] MASK = tap_mask(N_STAGES);
  localparam logic [N_STAGES-1:0] ONE = N_STAGES'(1);

  logic fb;

  assign fb = ^(state & MASK[N_STAGES-1:0]);

  // The all-zero state is a lock-up point for an XOR LFSR, so it is never loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
    end else if (load) begin
      state <= (seed == '0) ? ONE : seed;
    end else if (step) begin
      state <= {state[N_STAGES-2:0], fb};
    end
  end

endmodule

// File: rtl/arbiter_puf_engine.sv
// Sequenced arbiter PUF measurement: LFSR challenges, clear/launch per vote,
// majority vote per response bit with an instability flag.
module arbiter_puf_engine
  import arbiter_puf_pkg::*;
#(
  parameter int N_STAGES      = 64,
  parameter int RESP_BITS     = 8,
  parameter int N_VOTES       = 5,
  parameter int CLR_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_STAGES-1:0]  seed,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] resp,
  output logic [RESP_BITS-1:0] unstable,
  output logic [N_STAGES-1:0]  puf_chal,
  output logic                 puf_clr,
  output logic                 puf_launch,
  input  logic                 puf_resp,
  output puf_state_e           dbg_state
);

  localparam int VW     = $clog2(N_VOTES + 1);
  localparam int BW     = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int PH_MAX = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PW-1:0] CLR_LAST    = PW'(CLR_CYCLES - 1);
  localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
  localparam logic [VW-1:0] VOTE_LAST   = VW'(N_VOTES - 1);
  localparam logic [VW-1:0] VOTE_HALF   = VW'(N_VOTES / 2);
  localparam logic [VW-1:0] VOTE_ALL    = VW'(N_VOTES);
  localparam logic [BW-1:0] BIT_LAST    = BW'(RESP_BITS - 1);

  // Handshake: start is sampled only in IDLE (one cycle accepts it, no queuing);
  // busy is high for the whole measurement and done pulses one cycle, with busy
  // low, in the same cycle resp/unstable take their new values.

  puf_state_e           state;
  logic [PW-1:0]        phase;
  logic [VW-1:0]        vote_cnt;
  logic [VW-1:0]        ones;
  logic [BW-1:0]        bit_cnt;
  logic [RESP_BITS-1:0] resp_sh;
  logic [RESP_BITS-1:0] unst_sh;
  logic [1:0]           sync_q;

  logic [VW-1:0]        ones_sum;
  logic [RESP_BITS-1:0] resp_next;
  logic [RESP_BITS-1:0] unst_next;
  logic                 sample_now;
  logic                 bit_end;
  logic                 lfsr_load;

  assign dbg_state  = state;
  assign sample_now = (state == ST_LAUNCH) && (phase == SETTLE_LAST);
  assign bit_end    = sample_now && (vote_cnt == VOTE_LAST);
  assign lfsr_load  = (state == ST_IDLE) && start;
  assign ones_sum   = ones + VW'(sync_q[1]);

  always_comb begin
    resp_next          = resp_sh;
    unst_next          = unst_sh;
    resp_next[bit_cnt] = (ones_sum > VOTE_HALF);
    unst_next[bit_cnt] = (ones_sum != '0) && (ones_sum != VOTE_ALL);
  end

  // The arbiter output is launched asynchronously to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], puf_resp};
    end
  end

  puf_chal_lfsr #(
    .N_STAGES(N_STAGES)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .step (bit_end),
    .seed (seed),
    .state(puf_chal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      phase      <= '0;
      vote_cnt   <= '0;
      ones       <= '0;
      bit_cnt    <= '0;
      resp_sh    <= '0;
      unst_sh    <= '0;
      resp       <= '0;
      unstable   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      puf_clr    <= 1'b1;
      puf_launch <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_CLEAR;
            phase      <= '0;
            vote_cnt   <= '0;
            ones       <= '0;
            bit_cnt    <= '0;
            busy       <= 1'b1;
            puf_clr    <= 1'b1;
            puf_launch <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (phase == CLR_LAST) begin
            phase      <= '0;
            state      <= ST_LAUNCH;
            puf_clr    <= 1'b0;
            puf_launch <= 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_LAUNCH: begin
          if (phase == SETTLE_LAST) begin
            phase      <= '0;
            puf_clr    <= 1'b1;
            puf_launch <= 1'b0;
            if (vote_cnt < VOTE_LAST) begin
              vote_cnt <= vote_cnt + 1'b1;
              ones     <= ones_sum;
              state    <= ST_CLEAR;
            end else begin
              vote_cnt <= '0;
              ones     <= '0;
              resp_sh  <= resp_next;
              unst_sh  <= unst_next;
              if (bit_cnt < BIT_LAST) begin
                bit_cnt <= bit_cnt + 1'b1;
                state   <= ST_CLEAR;
              end else begin
                // Final bit folds straight into the visible outputs.
                state    <= ST_DONE;
                resp     <= resp_next;
                unstable <= unst_next;
                busy     <= 1'b0;
                done     <= 1'b1;
              end
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_puf_engine.sv
// Scoreboard bench for arbiter_puf_engine with a behavioural arbiter model.
module tb_arbiter_puf_engine;
  import arbiter_puf_pkg::*;

  localparam int N   = 64;
  localparam int RB  = 8;
  localparam int NV  = 5;
  localparam int RUN = 240;
  localparam int PER = 242;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  seed;
  logic          busy;
  logic          done;
  logic [RB-1:0] resp;
  logic [RB-1:0] unstable;
  logic [N-1:0]  puf_chal;
  logic          puf_clr;
  logic          puf_launch;
  logic          puf_resp;
  puf_state_e    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0]  exp_q [$];
  int           done_q [$];
  logic [N-1:0] chal_q [$];
  int           acc_q [$];

  int          mode = 0;
  logic [39:0] vote_bits = '0;
  int          launch_idx = 0;
  logic        prev_launch = 1'b0;

  arbiter_puf_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .resp      (resp),
    .unstable  (unstable),
    .puf_chal  (puf_chal),
    .puf_clr   (puf_clr),
    .puf_launch(puf_launch),
    .puf_resp  (puf_resp),
    .dbg_state (dbg_state)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] x);
    return {x[N-2:0], x[63] ^ x[62] ^ x[60] ^ x[59]};
  endfunction

  // reference model: challenge list, per-bit vote tally, result and timing
  task automatic push_run(input logic [N-1:0] sd, input int acc);
    logic [N-1:0]  c;
    logic [RB-1:0] r;
    logic [RB-1:0] u;
    int            ones;
    logic          v;
    c = (sd == '0) ? N'(1) : sd;
    r = '0;
    u = '0;
    for (int b = 0; b < RB; b++) begin
      ones = 0;
      for (int k = 0; k < NV; k++) begin
        chal_q.push_back(c);
        if (mode == 0)      v = 1'b1;
        else if (mode == 1) v = ^c;
        else                v = vote_bits[6'(b * NV + k)];
        ones += int'(v);
      end
      if (ones > NV / 2) r = r | (RB'(1) << b);
      if (ones != 0 && ones != NV) u = u | (RB'(1) << b);
      c = lfsr_next(c);
    end
    exp_q.push_back({r, u});
    done_q.push_back(acc + RUN);
    acc_q.push_back(acc);
  endtask

  // monitor + behavioural arbiter
  always @(negedge clk) begin
    logic        eb;
    int          dc;
    logic [15:0] ex;
    if (!rst) begin
      eb = 1'b0;
      foreach (acc_q[i]) if (cyc >= acc_q[i] && cyc <= acc_q[i] + RUN - 1) eb = 1'b1;
      check("busy", N'(busy), N'(eb));
      if (done) begin
        if (done_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL done: unexpected pulse at cycle %0d, required none", cyc);
        end else begin
          dc = done_q.pop_front();
          ex = exp_q.pop_front();
          check("done_cycle", N'(cyc), N'(dc));
          check("resp", N'(resp), N'(ex[15:8]));
          check("unstable", N'(unstable), N'(ex[7:0]));
        end
      end
      if (puf_launch && !prev_launch) begin
        if (chal_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL launch: unexpected launch with chal %0h, required none", puf_chal);
        end else begin
          check("puf_chal", puf_chal, chal_q.pop_front());
        end
        launch_idx++;
      end
    end
    prev_launch = puf_launch;
    case (mode)
      0:       puf_resp = 1'b1;
      1:       puf_resp = puf_launch ? ^puf_chal : 1'b0;
      default: puf_resp = puf_launch ? vote_bits[6'((launch_idx - 1) % 40)] : 1'b0;
    endcase
  end

  // driver tasks
  task automatic flush();
    exp_q.delete();
    done_q.delete();
    chal_q.delete();
    acc_q.delete();
  endtask

  task automatic wait_all();
    for (int i = 0; i < 600 && done_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (done_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: %0d done pulses missing, required 0", done_q.size());
      flush();
    end
    repeat (3) @(negedge clk);
    check("chal_left", N'(chal_q.size()), N'(0));
  endtask

  task automatic run_one(input logic [N-1:0] sd, input bit wait_done);
    @(negedge clk);
    seed       = sd;
    start      = 1'b1;
    launch_idx = 0;
    push_run(sd, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    if (wait_done) wait_all();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, N'(busy), N'(0));
    check({tag, "_done"}, N'(done), N'(0));
    check({tag, "_resp"}, N'(resp), N'(0));
    check({tag, "_unstable"}, N'(unstable), N'(0));
    check({tag, "_chal"}, puf_chal, N'(0));
    check({tag, "_clr"}, N'(puf_clr), N'(1));
    check({tag, "_launch"}, N'(puf_launch), N'(0));
    check({tag, "_state"}, N'(dbg_state), N'(ST_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc0;
    logic [N-1:0] sd;
    rst   = 1'b1;
    start = 1'b0;
    seed  = '0;
    #3;
    check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    mode = 0;
    run_one(N'(1), 1'b1);

    mode = 1;
    run_one(N'(1), 1'b1);
    run_one('0, 1'b1);

    mode = 2;
    vote_bits = 40'h0B;
    run_one({$urandom, $urandom}, 1'b1);
    vote_bits = 40'h12;
    run_one({$urandom, $urandom}, 1'b1);

    // abort during vote 3 of bit 2
    mode = 1;
    run_one({$urandom, $urandom}, 1'b0);
    for (int i = 0; i < 400 && launch_idx < 14; i++) begin
      @(negedge clk);
      #1;
    end
    check("abort_point", N'(launch_idx), N'(14));
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("abort");
    flush();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    run_one({$urandom, $urandom}, 1'b1);

    for (int i = 0; i < 4; i++) begin
      mode = 2;
      vote_bits = {8'($urandom), $urandom};
      run_one({$urandom, $urandom}, 1'b1);
      mode = 1;
      run_one({$urandom_range(1, 3) == 1 ? 32'h0 : $urandom, $urandom}, 1'b1);
    end

    // start held high across three back-to-back runs
    mode = 1;
    sd = {$urandom, $urandom};
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    acc0  = cyc + 1;
    push_run(sd, acc0);
    push_run(sd, acc0 + PER);
    push_run(sd, acc0 + 2 * PER);
    while (cyc < acc0 + 2 * PER) @(negedge clk);
    start = 1'b0;
    wait_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
